// File: rtl/p4_router_pkg.sv
// Shared types and helpers for the P4 router egress metadata path.
//   egr_meta_state_t   : state encoding of the metadata-attach FSM
//   egr_sel_from_meta(): extracts the egress port select from a metadata word
//   EGR_META_CNT_WIDTH : width of the statistics counters
package p4_router_pkg;

  localparam int unsigned EGR_META_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } egr_meta_state_t;

  // Keeps the low sel_width bits of the metadata word; everything above is cleared.
  function automatic logic [31:0] egr_sel_from_meta(input logic [31:0] meta,
                                                    input int unsigned sel_width);
    logic [31:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < sel_width) begin
        sel[i] = meta[i];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/p4_router_meta_fifo.sv
// Synchronous FIFO holding per-packet user metadata.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   push_i, wdata_i    : write request and data; dropped when full unless popping
//   pop_i, rdata_o     : read request and head-of-queue data (show-ahead)
//   full_o, empty_o    : occupancy flags
// When full, a push in the same cycle as a pop is accepted (pop-then-push).
module p4_router_meta_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  // Pointers carry one wrap bit to tell full from empty.
  logic [PtrW:0]    wptr_q, wptr_d;
  logic [PtrW:0]    rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      wptr_d = wptr_q + {{PtrW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rptr_d = rptr_q + {{PtrW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/p4_router_egr_meta_attach.sv
// Attaches VNP4 per-packet metadata to its packet and selects the egress port.
// Ports:
//   clk_ifc, areset_ifc      : clock, asynchronous active-low reset
//   data_in_*                : AXIS packet stream from VNP4 (tuser not used)
//   user_metadata_in(_valid) : one metadata word per packet, single-cycle strobe
//   data_out_*               : AXIS stream to egress, tuser = egress port select
//   drop_count               : saturating count of out-of-range drops
//   meta_overflow_count      : saturating count of metadata words lost to a full FIFO
//   drop_pulse               : one-cycle pulse after a dropped packet's last beat
// Build option P4_ROUTER_EGR_META_PORT_CHECK_EN enables the out-of-range check and
// the drop path; without it every packet is forwarded with tuser = sel truncated.
module p4_router_egr_meta_attach
  import p4_router_pkg::*;
#(
  parameter int unsigned DATA_BYTES              = 64,
  parameter int unsigned USER_METADATA_WIDTH     = 16,
  parameter int unsigned EGR_SPEC_METADATA_WIDTH = 8,
  parameter int unsigned NUM_EGR_PHYS_PORTS      = 4,
  parameter int unsigned META_FIFO_DEPTH         = 8,
  localparam int unsigned TuserW = (NUM_EGR_PHYS_PORTS > 1) ? $clog2(NUM_EGR_PHYS_PORTS) : 1
) (
  input  logic                               clk_ifc,
  input  logic                               areset_ifc,
  input  logic [DATA_BYTES*8-1:0]            data_in_tdata,
  input  logic [DATA_BYTES-1:0]              data_in_tkeep,
  input  logic                               data_in_tlast,
  input  logic                               data_in_tvalid,
  output logic                               data_in_tready,
  input  logic [USER_METADATA_WIDTH-1:0]     user_metadata_in,
  input  logic                               user_metadata_in_valid,
  output logic [DATA_BYTES*8-1:0]            data_out_tdata,
  output logic [DATA_BYTES-1:0]              data_out_tkeep,
  output logic                               data_out_tlast,
  output logic [TuserW-1:0]                  data_out_tuser,
  output logic                               data_out_tvalid,
  input  logic                               data_out_tready,
  output logic [EGR_META_CNT_WIDTH-1:0]      drop_count,
  output logic [EGR_META_CNT_WIDTH-1:0]      meta_overflow_count,
  output logic                               drop_pulse
);

  localparam int unsigned SliceW = DATA_BYTES * 9 + 1 + TuserW;

  // Reset: asserts asynchronously, releases two clocks after areset_ifc rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_ifc or negedge areset_ifc) begin
    if (!areset_ifc) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Metadata FIFO
  logic                           fifo_pop, fifo_full, fifo_empty;
  logic [USER_METADATA_WIDTH-1:0] fifo_rdata;

  p4_router_meta_fifo #(
    .Width(USER_METADATA_WIDTH),
    .Depth(META_FIFO_DEPTH)
  ) u_meta_fifo (
    .clk_i  (clk_ifc),
    .rst_ni (rst_n),
    .push_i (user_metadata_in_valid),
    .wdata_i(user_metadata_in),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  logic [31:0] sel_full;
  assign sel_full = egr_sel_from_meta(32'(fifo_rdata), EGR_SPEC_METADATA_WIDTH);

`ifdef P4_ROUTER_EGR_META_PORT_CHECK_EN
  logic sel_in_range;
  assign sel_in_range = (sel_full < NUM_EGR_PHYS_PORTS);
`else
  logic unused_sel;
  assign unused_sel = ^sel_full;
`endif

  // FSM
  egr_meta_state_t   state_q, state_d;
  logic [TuserW-1:0] user_q, user_d;
  logic              slice_in_valid, slice_in_ready;
  logic              drop_evt;

  always_comb begin
    state_d        = state_q;
    user_d         = user_q;
    fifo_pop       = 1'b0;
    data_in_tready = 1'b0;
    slice_in_valid = 1'b0;
    drop_evt       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Bubble cycle: only the metadata is consumed here, never a beat.
        if (data_in_tvalid && !fifo_empty) begin
          fifo_pop = 1'b1;
          user_d   = sel_full[TuserW-1:0];
`ifdef P4_ROUTER_EGR_META_PORT_CHECK_EN
          state_d  = sel_in_range ? StFwd : StDrop;
`else
          state_d  = StFwd;
`endif
        end
      end
      StFwd: begin
        data_in_tready = slice_in_ready;
        slice_in_valid = data_in_tvalid;
        if (data_in_tvalid && slice_in_ready && data_in_tlast) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        data_in_tready = 1'b1;
        if (data_in_tvalid && data_in_tlast) begin
          state_d  = StIdle;
          drop_evt = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ifc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      user_q  <= user_d;
    end
  end

  // Output register slice with a skid entry; input ready depends only on skid occupancy.
  logic [SliceW-1:0] slice_in, out_q, out_d, skid_q, skid_d;
  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic              in_fire, out_fire;

  assign slice_in       = {data_in_tdata, data_in_tkeep, data_in_tlast, user_q};
  assign slice_in_ready = ~skid_valid_q;
  assign in_fire        = slice_in_valid & slice_in_ready;
  assign out_fire       = out_valid_q & data_out_tready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (out_fire) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || data_out_tready) begin
        out_d       = slice_in;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = slice_in;
        skid_valid_d = 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ifc or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign {data_out_tdata, data_out_tkeep, data_out_tlast, data_out_tuser} = out_q;
  assign data_out_tvalid = out_valid_q;

  // Counters
  logic [EGR_META_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (user_metadata_in_valid && fifo_full && !fifo_pop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ifc or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign meta_overflow_count = ovf_cnt_q;

`ifdef P4_ROUTER_EGR_META_PORT_CHECK_EN
  logic [EGR_META_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                          drop_pulse_q, drop_pulse_d;

  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    drop_pulse_d = drop_evt;
    if (drop_evt && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ifc or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
  assign drop_count  = '0;
  assign drop_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_p4_router_egr_meta_attach.sv
// Scoreboard bench for p4_router_egr_meta_attach: the stimulus side pushes expected
// output beats into a queue, an independent monitor pops and compares on every
// data_out handshake and also checks AXIS hold rules while stalled.
module tb_p4_router_egr_meta_attach;

  localparam int unsigned DB     = 64;
  localparam int unsigned UMW    = 16;
  localparam int unsigned ESW    = 8;
  localparam int unsigned NP     = 4;
  localparam int unsigned FD     = 8;
  localparam int unsigned TW     = 2;
  localparam int          Budget = 2000;
`ifdef P4_ROUTER_EGR_META_PORT_CHECK_EN
  localparam bit PortCheck = 1'b1;
`else
  localparam bit PortCheck = 1'b0;
`endif

  typedef struct packed {
    logic [DB*8-1:0] data;
    logic [DB-1:0]   keep;
    logic            last;
    logic [TW-1:0]   user;
  } beat_t;

  logic            clk = 1'b0;
  logic            areset_ifc = 1'b0;
  logic [DB*8-1:0] data_in_tdata = '0;
  logic [DB-1:0]   data_in_tkeep = '0;
  logic            data_in_tlast = 1'b0;
  logic            data_in_tvalid = 1'b0;
  logic            data_in_tready;
  logic [UMW-1:0]  user_metadata_in = '0;
  logic            user_metadata_in_valid = 1'b0;
  logic [DB*8-1:0] data_out_tdata;
  logic [DB-1:0]   data_out_tkeep;
  logic            data_out_tlast;
  logic [TW-1:0]   data_out_tuser;
  logic            data_out_tvalid;
  logic            data_out_tready = 1'b1;
  logic [31:0]     drop_count, meta_overflow_count;
  logic            drop_pulse;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    exp_drops = 0;
  int    exp_ovf = 0;
  int    pulses_seen = 0;
  bit    in_rst = 1'b1;
  bit    bp = 1'b0;

  always #5 clk = ~clk;

  p4_router_egr_meta_attach #(
    .DATA_BYTES(DB),
    .USER_METADATA_WIDTH(UMW),
    .EGR_SPEC_METADATA_WIDTH(ESW),
    .NUM_EGR_PHYS_PORTS(NP),
    .META_FIFO_DEPTH(FD)
  ) dut (
    .clk_ifc(clk),
    .areset_ifc(areset_ifc),
    .data_in_tdata(data_in_tdata),
    .data_in_tkeep(data_in_tkeep),
    .data_in_tlast(data_in_tlast),
    .data_in_tvalid(data_in_tvalid),
    .data_in_tready(data_in_tready),
    .user_metadata_in(user_metadata_in),
    .user_metadata_in_valid(user_metadata_in_valid),
    .data_out_tdata(data_out_tdata),
    .data_out_tkeep(data_out_tkeep),
    .data_out_tlast(data_out_tlast),
    .data_out_tuser(data_out_tuser),
    .data_out_tvalid(data_out_tvalid),
    .data_out_tready(data_out_tready),
    .drop_count(drop_count),
    .meta_overflow_count(meta_overflow_count),
    .drop_pulse(drop_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: forwarding decision and egress port from the metadata word.
  function automatic bit pkt_fwd(input logic [UMW-1:0] meta);
    logic [ESW-1:0] sel;
    sel = meta[ESW-1:0];
    return !PortCheck || (int'(sel) < int'(NP));
  endfunction

  function automatic logic [TW-1:0] pkt_user(input logic [UMW-1:0] meta);
    logic [ESW-1:0] sel;
    int             u;
    sel = meta[ESW-1:0];
    u   = int'(sel) % (1 << TW);
    return u[TW-1:0];
  endfunction

  function automatic logic [UMW-1:0] mk_meta(input int sel);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'($urandom);
    lo = 8'(sel);
    return {hi, lo};
  endfunction

  // Output ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor
  initial begin
    beat_t got, prev, e;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (in_rst) begin
        prev_stall = 1'b0;
        continue;
      end
      got = {data_out_tdata, data_out_tkeep, data_out_tlast, data_out_tuser};
      if (prev_stall) begin
        total++;
        if (!data_out_tvalid || got !== prev) begin
          bad++;
          $display("FAIL hold: valid=%0b user=%0h last=%0b, required valid=1 user=%0h last=%0b",
                   data_out_tvalid, got.user, got.last, prev.user, prev.last);
        end
      end
      if (data_out_tvalid && data_out_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected beat user=%0h last=%0b", got.user, got.last);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL beat: got user=%0h last=%0b keep=%0h data[31:0]=%0h, required user=%0h last=%0b keep=%0h data[31:0]=%0h",
                     got.user, got.last, got.keep, got.data[31:0],
                     e.user, e.last, e.keep, e.data[31:0]);
          end
        end
      end
      if (drop_pulse) pulses_seen++;
      prev_stall = data_out_tvalid && !data_out_tready;
      prev       = got;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic push_meta(input logic [UMW-1:0] w);
    user_metadata_in       = w;
    user_metadata_in_valid = 1'b1;
    @(posedge clk);
    #1;
    user_metadata_in_valid = 1'b0;
  endtask

  task automatic drive_beat(input int b, input int n, input logic [UMW-1:0] meta, input bit fwd);
    beat_t e;
    for (int i = 0; i < DB / 4; i++) data_in_tdata[32*i +: 32] = $urandom;
    data_in_tkeep  = {$urandom, $urandom};
    data_in_tlast  = (b == n - 1);
    data_in_tvalid = 1'b1;
    if (fwd) begin
      e.data = data_in_tdata;
      e.keep = data_in_tkeep;
      e.last = data_in_tlast;
      e.user = pkt_user(meta);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (data_in_tready) break;
      n++;
      if (n > Budget) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: tready=0 after %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [UMW-1:0] meta, input int n);
    bit fwd;
    fwd = pkt_fwd(meta);
    for (int b = 0; b < n; b++) begin
      drive_beat(b, n, meta, fwd);
      wait_accept();
    end
    data_in_tvalid = 1'b0;
    if (!fwd) exp_drops++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < Budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
    check({name, "_drop_pulses"}, 64'(pulses_seen), 64'(exp_drops));
    check({name, "_ovf_count"}, 64'(meta_overflow_count), 64'(exp_ovf));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_tvalid"}, 64'(data_out_tvalid), 64'(0));
    check({name, "_in_tready"}, 64'(data_in_tready), 64'(0));
    check({name, "_drop_count"}, 64'(drop_count), 64'(0));
    check({name, "_ovf_count"}, 64'(meta_overflow_count), 64'(0));
    check({name, "_drop_pulse"}, 64'(drop_pulse), 64'(0));
    check({name, "_tuser"}, 64'(data_out_tuser), 64'(0));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    areset_ifc = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    in_rst = 1'b0;
  endtask

  initial begin
    logic [UMW-1:0] metas[$];
    logic [UMW-1:0] m;

    // Reset
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();

    // Forward: sels 0, 1, 3 queued ahead of their data
    metas = {};
    foreach (metas[i]) metas.delete(i);
    metas.push_back(mk_meta(0));
    metas.push_back(mk_meta(1));
    metas.push_back(mk_meta(3));
    foreach (metas[i]) push_meta(metas[i]);
    foreach (metas[i]) send_pkt(metas[i], 4);
    drain("fwd");
    check_counters("fwd");

    // Out-of-range select on a 6-beat packet
    push_meta(mk_meta(5));
    send_pkt(mk_meta(5), 6);
    drain("drop");
    check_counters("drop");

    // Overflow: 10 pushes into the 8-deep FIFO with no data, then consume 8
    metas = {};
    for (int i = 0; i < 10; i++) begin
      m = mk_meta($urandom_range(0, 7));
      metas.push_back(m);
      push_meta(m);
    end
    exp_ovf += 2;
    @(posedge clk);
    #1;
    check("ovf_after_push", 64'(meta_overflow_count), 64'(exp_ovf));
    for (int i = 0; i < 8; i++) send_pkt(metas[i], $urandom_range(1, 4));
    drain("ovf");
    check_counters("ovf");

    // Late metadata: beat waits 5 cycles before its metadata arrives
    m = mk_meta(1);
    drive_beat(0, 3, m, pkt_fwd(m));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("late_tready_wait", 64'(data_in_tready), 64'(0));
      @(posedge clk);
      #1;
    end
    user_metadata_in       = m;
    user_metadata_in_valid = 1'b1;
    @(negedge clk);
    check("late_tready_push", 64'(data_in_tready), 64'(0));
    @(posedge clk);
    #1;
    user_metadata_in_valid = 1'b0;
    @(negedge clk);
    check("late_tready_pop", 64'(data_in_tready), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("late_tready_fwd", 64'(data_in_tready), 64'(1));
    @(posedge clk);
    #1;
    for (int b = 1; b < 3; b++) begin
      drive_beat(b, 3, m, pkt_fwd(m));
      wait_accept();
    end
    data_in_tvalid = 1'b0;
    drain("late");

    // Backpressure across 1-beat and 64-beat packets
    bp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m = mk_meta($urandom_range(0, 7));
      push_meta(m);
      send_pkt(m, (i % 2 == 0) ? 1 : 64);
    end
    drain("bp");
    check_counters("bp");

    // Random mix, including wide out-of-range selects
    for (int i = 0; i < 20; i++) begin
      bp = 1'($urandom_range(0, 1));
      m  = mk_meta(($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 7));
      push_meta(m);
      send_pkt(m, $urandom_range(1, 8));
    end
    drain("rand");
    check_counters("rand");

    // Reset at beat 3 of an 8-beat packet
    bp = 1'b0;
    m  = mk_meta(1);
    push_meta(m);
    for (int b = 0; b < 3; b++) begin
      drive_beat(b, 8, m, 1'b1);
      wait_accept();
    end
    in_rst     = 1'b1;
    areset_ifc = 1'b0;
    #1;
    check_reset_outputs("midrst");
    data_in_tvalid = 1'b0;
    exp_q.delete();
    exp_drops   = 0;
    exp_ovf     = 0;
    pulses_seen = 0;
    release_reset();
    m = mk_meta(2);
    push_meta(m);
    send_pkt(m, 2);
    drain("postrst");
    check_counters("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
